// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, per-byte edge budget and CPOL/CPHA decode.
package spi_pkg;

    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;

    // Eight bits need one leading and one trailing SCLK edge each
    localparam logic [4:0] EDGES_PER_BYTE = 5'd16;

    function automatic logic cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-bit timer, 16-edge budget per byte, and one-cycle
// leading/trailing edge strobes that the shift logic consumes.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int   CLKS_PER_HALF_BIT = 2,
    parameter logic CPOL              = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic start,
    output logic spi_clk,
    output logic leading_edge,
    output logic trailing_edge,
    output logic busy
);

    localparam int HALF_CNT_W = $clog2(2 * CLKS_PER_HALF_BIT);
    localparam logic [HALF_CNT_W-1:0] LEAD_CNT  = HALF_CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [HALF_CNT_W-1:0] TRAIL_CNT = HALF_CNT_W'(2 * CLKS_PER_HALF_BIT - 1);
    localparam logic [HALF_CNT_W-1:0] CNT_ONE   = HALF_CNT_W'(1);

    logic [HALF_CNT_W-1:0] half_cnt_r;
    logic [4:0]            edge_cnt_r;
    logic                  spi_clk_r;
    logic                  leading_r;
    logic                  trailing_r;

    // Half-bit timer, edge budget and SCLK toggling
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            half_cnt_r <= '0;
            edge_cnt_r <= 5'd0;
            spi_clk_r  <= CPOL;
            leading_r  <= 1'b0;
            trailing_r <= 1'b0;
        end else begin
            leading_r  <= 1'b0;
            trailing_r <= 1'b0;
            if (start) begin
                edge_cnt_r <= EDGES_PER_BYTE;
                half_cnt_r <= '0;
            end else if (edge_cnt_r != 5'd0) begin
                if (half_cnt_r == TRAIL_CNT) begin
                    half_cnt_r <= '0;
                    edge_cnt_r <= edge_cnt_r - 5'd1;
                    trailing_r <= 1'b1;
                    spi_clk_r  <= ~spi_clk_r;
                end else if (half_cnt_r == LEAD_CNT) begin
                    half_cnt_r <= half_cnt_r + CNT_ONE;
                    edge_cnt_r <= edge_cnt_r - 5'd1;
                    leading_r  <= 1'b1;
                    spi_clk_r  <= ~spi_clk_r;
                end else begin
                    half_cnt_r <= half_cnt_r + CNT_ONE;
                end
            end else begin
                half_cnt_r <= '0;
                spi_clk_r  <= CPOL;
            end
        end
    end

    assign spi_clk       = spi_clk_r;
    assign leading_edge  = leading_r;
    assign trailing_edge = trailing_r;
    assign busy          = (edge_cnt_r != 5'd0);

endmodule

// File: rtl/spi_master.sv
// Single-byte full-duplex SPI master: valid/ready byte handshake, MSB-first
// shifting on MOSI and MISO capture, timed by spi_clk_gen.
module spi_master
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI
);

    localparam logic CPOL_C = cpol(2'(SPI_MODE));
    localparam logic CPHA_C = cpha(2'(SPI_MODE));

    logic       accept_s;
    logic       lead_s;
    logic       trail_s;
    logic       busy_s;
    logic       sclk_s;
    logic       tx_shift_s;
    logic       rx_sample_s;

    logic       tx_ready_r;
    logic       accept_d_r;
    logic [7:0] tx_byte_r;
    logic [2:0] tx_bit_idx_r;
    logic       tx_done_r;
    logic       mosi_r;
    logic [7:0] rx_shift_r;
    logic [2:0] rx_bit_idx_r;
    logic [7:0] rx_byte_r;
    logic       rx_dv_r;

    assign accept_s    = i_TX_DV & tx_ready_r;
    assign tx_shift_s  = CPHA_C ? lead_s  : trail_s;
    assign rx_sample_s = CPHA_C ? trail_s : lead_s;

    spi_clk_gen #(
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT),
        .CPOL              (CPOL_C)
    ) u_clk_gen (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .start         (accept_s),
        .spi_clk       (sclk_s),
        .leading_edge  (lead_s),
        .trailing_edge (trail_s),
        .busy          (busy_s)
    );

    // Handshake: Ready drops on accept and returns once the clock generator is idle
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_ready_r <= 1'b0;
            accept_d_r <= 1'b0;
            tx_byte_r  <= 8'h00;
        end else begin
            accept_d_r <= accept_s;
            if (accept_s) begin
                tx_ready_r <= 1'b0;
                tx_byte_r  <= i_TX_Byte;
            end else begin
                tx_ready_r <= ~busy_s;
            end
        end
    end

    // MOSI shifter; with CPHA=0 bit 7 is presented before the first SCLK edge,
    // so the eighth trailing edge has nothing left to drive
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            mosi_r       <= 1'b0;
            tx_bit_idx_r <= 3'd7;
            tx_done_r    <= 1'b0;
        end else if (tx_ready_r) begin
            tx_bit_idx_r <= 3'd7;
            tx_done_r    <= 1'b0;
        end else if (accept_d_r && !CPHA_C) begin
            mosi_r       <= tx_byte_r[7];
            tx_bit_idx_r <= 3'd6;
        end else if (tx_shift_s && !tx_done_r) begin
            mosi_r       <= tx_byte_r[tx_bit_idx_r];
            tx_bit_idx_r <= tx_bit_idx_r - 3'd1;
            tx_done_r    <= (tx_bit_idx_r == 3'd0);
        end
    end

    // MISO capture into a private shifter; the visible byte only changes with RX_DV
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_shift_r   <= 8'h00;
            rx_bit_idx_r <= 3'd7;
            rx_byte_r    <= 8'h00;
            rx_dv_r      <= 1'b0;
        end else begin
            rx_dv_r <= 1'b0;
            if (tx_ready_r) begin
                rx_bit_idx_r <= 3'd7;
            end else if (rx_sample_s) begin
                rx_shift_r[rx_bit_idx_r] <= i_SPI_MISO;
                rx_bit_idx_r             <= rx_bit_idx_r - 3'd1;
                if (rx_bit_idx_r == 3'd0) begin
                    rx_byte_r <= {rx_shift_r[7:1], i_SPI_MISO};
                    rx_dv_r   <= 1'b1;
                end
            end
        end
    end

    assign o_TX_Ready = tx_ready_r;
    assign o_RX_DV    = rx_dv_r;
    assign o_RX_Byte  = rx_byte_r;
    assign o_SPI_Clk  = sclk_s;
    assign o_SPI_MOSI = mosi_r;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: mode 0 / half 2 with MISO looped back, and
// mode 3 / half 4 with MISO tied high, checked through MOSI/RX scoreboards.
module tb_spi_master;

    localparam int H0 = 2;
    localparam int H1 = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dv;
    logic [1:0] ready;
    logic [1:0] rx_dv;
    logic [1:0] sclk;
    logic [1:0] mosi;
    logic [1:0] miso;
    logic [7:0] tx_byte [2];
    logic [7:0] rx_byte [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rx_count [2] = '{0, 0};

    // entries are {dut index, byte}
    logic [8:0] exp_tx_q [$];
    logic [8:0] exp_rx_q [$];

    logic [7:0] hello [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                               8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h00};

    assign miso = {1'b1, mosi[0]};

    always #5 clk = ~clk;

    spi_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(H0)) dut0 (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .i_TX_Byte  (tx_byte[0]),
        .i_TX_DV    (dv[0]),
        .o_TX_Ready (ready[0]),
        .o_RX_DV    (rx_dv[0]),
        .o_RX_Byte  (rx_byte[0]),
        .o_SPI_Clk  (sclk[0]),
        .i_SPI_MISO (miso[0]),
        .o_SPI_MOSI (mosi[0])
    );

    spi_master #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(H1)) dut3 (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .i_TX_Byte  (tx_byte[1]),
        .i_TX_DV    (dv[1]),
        .o_TX_Ready (ready[1]),
        .o_RX_DV    (rx_dv[1]),
        .o_RX_Byte  (rx_byte[1]),
        .o_SPI_Clk  (sclk[1]),
        .i_SPI_MISO (miso[1]),
        .o_SPI_MOSI (mosi[1])
    );

    // Slave-side monitor: both modes sample MOSI on rising SCLK; RX_DV pops the RX scoreboard
    int         nbit [2] = '{0, 0};
    int         last_rise [2] = '{0, 0};
    logic [7:0] mshift [2];
    logic [1:0] sclk_prev = 2'b00;
    logic [1:0] rxdv_prev = 2'b00;

    always @(negedge clk) begin
        logic [7:0] nshift;
        logic [8:0] e;
        int per;
        for (int g = 0; g < 2; g++) begin
            per = (g == 0) ? 2 * H0 : 2 * H1;
            if (!rst_n) begin
                nbit[g] = 0;
            end else begin
                if (sclk[g] === 1'b1 && sclk_prev[g] === 1'b0) begin
                    if (nbit[g] != 0) begin
                        checks++;
                        assert (cyc - last_rise[g] == per) else begin
                            failures++;
                            $error("FAIL sclk_period dut=%0d got=%0d exp=%0d", g, cyc - last_rise[g], per);
                        end
                    end
                    last_rise[g] = cyc;
                    nshift = {mshift[g][6:0], mosi[g]};
                    mshift[g] = nshift;
                    nbit[g]++;
                    if (nbit[g] == 8) begin
                        nbit[g] = 0;
                        checks++;
                        assert (exp_tx_q.size() != 0) else begin
                            failures++;
                            $error("FAIL mosi_unexpected dut=%0d got=%02h exp=none", g, nshift);
                        end
                        if (exp_tx_q.size() != 0) begin
                            e = exp_tx_q.pop_front();
                            checks++;
                            assert ({g[0], nshift} === e) else begin
                                failures++;
                                $error("FAIL mosi_byte dut=%0d got=%0d/%02h exp=%0d/%02h", g, g, nshift, e[8], e[7:0]);
                            end
                        end
                    end
                end
                if (rx_dv[g] === 1'b1) begin
                    rx_count[g]++;
                    checks++;
                    assert (rxdv_prev[g] === 1'b0) else begin
                        failures++;
                        $error("FAIL rx_dv_width dut=%0d got=2+ cycles exp=1", g);
                    end
                    checks++;
                    assert (exp_rx_q.size() != 0) else begin
                        failures++;
                        $error("FAIL rx_unexpected dut=%0d got=%02h exp=none", g, rx_byte[g]);
                    end
                    if (exp_rx_q.size() != 0) begin
                        e = exp_rx_q.pop_front();
                        checks++;
                        assert ({g[0], rx_byte[g]} === e) else begin
                            failures++;
                            $error("FAIL rx_byte dut=%0d got=%0d/%02h exp=%0d/%02h", g, g, rx_byte[g], e[8], e[7:0]);
                        end
                    end
                end
            end
            sclk_prev[g] = sclk[g];
            rxdv_prev[g] = rx_dv[g];
        end
        cyc++;
    end

    // Waits for Ready, issues one accepted DV pulse, then counts cycles until Ready returns
    task automatic send(input int g, input logic [7:0] b, input int poke_at, output int low);
        int n;
        n = 0;
        while (ready[g] !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        assert (ready[g] === 1'b1) else begin
            failures++;
            $error("FAIL ready_wait dut=%0d got=%b exp=1", g, ready[g]);
        end
        exp_tx_q.push_back({g[0], b});
        tx_byte[g] = b;
        dv[g] = 1'b1;
        @(posedge clk); #1;
        dv[g] = 1'b0;
        low = 0;
        while (ready[g] !== 1'b1 && low < 1000) begin
            if (poke_at != 0 && low == poke_at) begin
                dv[g] = 1'b1;
                tx_byte[g] = 8'hFF;
            end else begin
                dv[g] = 1'b0;
            end
            @(posedge clk); #1;
            low++;
        end
        dv[g] = 1'b0;
    endtask

    task automatic check_low(input string tag, input int low, input int h);
        checks++;
        assert (low >= 16 * h && low <= 16 * h + 2) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d..%0d", tag, low, 16 * h, 16 * h + 2);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Watchdog: a hung handshake must still end the run
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low;
        int rx_before;
        int toggles;
        int n;
        logic prev;

        dv = 2'b00;
        tx_byte[0] = 8'h00;
        tx_byte[1] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check_bit("rst_ready0", ready[0], 1'b0);
        check_bit("rst_sclk0", sclk[0], 1'b0);
        check_bit("rst_mosi0", mosi[0], 1'b0);
        check_bit("rst_rxdv0", rx_dv[0], 1'b0);
        check_int("rst_rxbyte0", int'(rx_byte[0]), 0);
        check_bit("rst_sclk3", sclk[1], 1'b1);
        check_bit("rst_ready3", ready[1], 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_bit("ready0_after_rst", ready[0], 1'b1);
        check_bit("ready3_after_rst", ready[1], 1'b1);

        // Mode 0, half 2, 0x48 looped back
        exp_rx_q.push_back({1'b0, 8'h48});
        send(0, 8'h48, 0, low);
        check_low("ready_low_m0", low, H0);
        check_int("rxbyte_m0", int'(rx_byte[0]), 8'h48);
        check_int("rxcount_m0", rx_count[0], 1);
        check_bit("sclk_idle_m0", sclk[0], 1'b0);

        // Mode 3, half 4, 0xA5 with MISO tied high
        exp_rx_q.push_back({1'b1, 8'hFF});
        send(1, 8'hA5, 0, low);
        check_low("ready_low_m3", low, H1);
        check_int("rxbyte_m3", int'(rx_byte[1]), 8'hFF);
        check_bit("sclk_idle_m3", sclk[1], 1'b1);
        check_bit("mosi_hold_m3", mosi[1], 1'b1);

        // Back-to-back "Hello World!\0" from a Ready-driven sequencer
        for (int i = 0; i < 13; i++) begin
            exp_rx_q.push_back({1'b0, hello[i]});
            send(0, hello[i], 0, low);
        end
        check_int("rxcount_hello", rx_count[0], 14);
        check_int("rxbyte_hello_last", int'(rx_byte[0]), 8'h00);

        // DV pulsed mid-transfer must be ignored
        exp_rx_q.push_back({1'b0, 8'h5A});
        send(0, 8'h5A, 10, low);
        check_low("ready_low_poke", low, H0);
        repeat (4 * H0) @(posedge clk);
        #1;
        check_int("rxcount_poke", rx_count[0], 15);
        check_int("rxbyte_poke", int'(rx_byte[0]), 8'h5A);
        check_bit("mosi_hold_m0", mosi[0], 1'b0);

        // Reset at SCLK edge 7 aborts without RX_DV
        rx_before = rx_count[0];
        tx_byte[0] = 8'h77;
        dv[0] = 1'b1;
        @(posedge clk); #1;
        dv[0] = 1'b0;
        toggles = 0;
        n = 0;
        prev = sclk[0];
        while (toggles < 7 && n < 500) begin
            @(posedge clk); #1;
            n++;
            if (sclk[0] !== prev) toggles++;
            prev = sclk[0];
        end
        check_int("sclk_edges_before_rst", toggles, 7);
        rst_n = 1'b0;
        #1;
        check_bit("abort_sclk", sclk[0], 1'b0);
        check_bit("abort_ready", ready[0], 1'b0);
        check_bit("abort_mosi", mosi[0], 1'b0);
        check_int("abort_rxbyte", int'(rx_byte[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_int("abort_no_rxdv", rx_count[0], rx_before);
        check_bit("abort_ready_back", ready[0], 1'b1);

        // Clean transfer after the abort
        exp_rx_q.push_back({1'b0, 8'h3C});
        send(0, 8'h3C, 0, low);
        check_low("ready_low_3c", low, H0);
        repeat (3) @(posedge clk);
        #1;
        check_int("rxbyte_3c", int'(rx_byte[0]), 8'h3C);
        check_int("rxcount_final0", rx_count[0], 16);
        check_int("rxcount_final3", rx_count[1], 1);
        check_int("exp_tx_drained", exp_tx_q.size(), 0);
        check_int("exp_rx_drained", exp_rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
